// File: rtl/dcache_assoc_array_if.sv
// ---------------------------------------------------------------------------
// dcache_assoc_array_if
// Request / response / victim bundle between the L1 data-cache controller
// (master) and the set-associative data/tag array (slave).
//   req_*    : one request per cycle; req_ready is driven by the array
//   resp_*   : registered response for the request accepted last cycle
//   victim_* : displaced / invalidated / miss-victim line for write-back
// ---------------------------------------------------------------------------
interface dcache_assoc_array_if #(
    parameter int WAYS        = 2,
    parameter int OFFSET_BITS = 5,
    parameter int ADDR_W      = 32
);
    localparam int LINE_W = 8 * (2 ** OFFSET_BITS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic [LINE_W-1:0] req_line;

    logic              resp_valid;
    logic              resp_hit;
    logic [WAY_W-1:0]  resp_way;
    logic [31:0]       resp_rdata;

    logic              victim_valid;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic [LINE_W-1:0] victim_line;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_be, req_line,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_rdata,
               victim_valid, victim_dirty, victim_addr, victim_line
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_be, req_line,
        output req_ready, resp_valid, resp_hit, resp_way, resp_rdata,
               victim_valid, victim_dirty, victim_addr, victim_line
    );
endinterface

// File: rtl/dcache_assoc_array.sv
// ---------------------------------------------------------------------------
// dcache_assoc_array
// Set-associative data/tag array for the L1 data cache: WAYS ways of
// 2^INDEX_BITS sets, per-line valid/dirty, true-LRU replacement via per-set
// age counters. After reset an initialisation sweep clears one set per
// cycle; afterwards one request per cycle is served with a registered
// one-cycle response.
// Ports:
//   clk       : clock, all state changes on rising edge
//   rst       : asynchronous active-high reset
//   bus       : dcache_assoc_array_if.slave (req_*, resp_*, victim_*)
//   init_done : initialisation sweep finished (equals req_ready)
// Request ops: 00 read, 01 write, 10 refill, 11 invalidate.
// ---------------------------------------------------------------------------
module dcache_assoc_array #(
    parameter int WAYS        = 2,
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 5,
    parameter int ADDR_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    dcache_assoc_array_if.slave      bus,
    output logic                     init_done
);
    localparam int SETS   = 2 ** INDEX_BITS;
    localparam int LINE_W = 8 * (2 ** OFFSET_BITS);
    localparam int TAG_W  = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W  = WAY_W;
    localparam int WSEL_W = OFFSET_BITS - 2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_REFILL = 2'b10,
        OP_INVAL  = 2'b11
    } op_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
    logic [LINE_W-1:0] data_mem  [WAYS][SETS];
    logic              valid_mem [WAYS][SETS];
    logic              dirty_mem [WAYS][SETS];
    logic [AGE_W-1:0]  age_mem   [WAYS][SETS];

    // ------------------------------------------------------------------
    // Control FSM and init sweep counter
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] init_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (&init_cnt) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    logic accept;
    assign bus.req_ready = (state_q == ST_RUN);
    assign init_done     = (state_q == ST_RUN);
    assign accept        = bus.req_valid & bus.req_ready;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    op_t                   op;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [WSEL_W-1:0]     wsel;
    logic [OFFSET_BITS+2:0] word_base;
    logic                  unused_addr_bits;

    assign op        = op_t'(bus.req_op);
    assign idx       = bus.req_addr[OFFSET_BITS +: INDEX_BITS];
    assign tag       = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign wsel      = bus.req_addr[OFFSET_BITS-1:2];
    assign word_base = {wsel, 5'b00000};
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // ------------------------------------------------------------------
    // Combinational lookup and victim selection
    // ------------------------------------------------------------------
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             found_inv;
    logic [WAY_W-1:0] vic_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_mem[WAY_W'(w)][idx] &&
                (tag_mem[WAY_W'(w)][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; with all ways valid the ages form a
    // permutation, so exactly one way carries the oldest age.
    always_comb begin
        found_inv = 1'b0;
        vic_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_inv && !valid_mem[WAY_W'(w)][idx]) begin
                found_inv = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_mem[WAY_W'(w)][idx] == AGE_W'(WAYS - 1)) begin
                    vic_way = WAY_W'(w);
                end
            end
        end
    end

    logic [LINE_W-1:0] hit_line;
    logic              hit_dirty;
    logic [LINE_W-1:0] vic_line;
    logic [TAG_W-1:0]  vic_tag;
    logic              vic_valid;
    logic              vic_dirty;
    logic [LINE_W-1:0] wr_line;

    assign hit_line  = data_mem[hit_way][idx];
    assign hit_dirty = dirty_mem[hit_way][idx];
    assign vic_line  = data_mem[vic_way][idx];
    assign vic_tag   = tag_mem[vic_way][idx];
    assign vic_valid = valid_mem[vic_way][idx];
    assign vic_dirty = dirty_mem[vic_way][idx];

    // Byte-enable merge of the write word into the hit line
    always_comb begin
        wr_line = hit_line;
        for (int unsigned b = 0; b < 4; b++) begin
            if (bus.req_be[b]) begin
                wr_line[{wsel, 2'(b), 3'b000} +: 8] = bus.req_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // LRU touch selection
    // ------------------------------------------------------------------
    logic             touch_en;
    logic [WAY_W-1:0] touch_way;
    logic [AGE_W-1:0] touch_age;

    always_comb begin
        touch_en  = 1'b0;
        touch_way = hit_way;
        case (op)
            OP_READ, OP_WRITE: touch_en = accept & hit;
            OP_REFILL: begin
                touch_en  = accept;
                touch_way = vic_way;
            end
            default: touch_en = 1'b0;
        endcase
    end

    assign touch_age = age_mem[touch_way][idx];

    // ------------------------------------------------------------------
    // Array update: init sweep or committed request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_mem[WAY_W'(w)][init_cnt] <= 1'b0;
                dirty_mem[WAY_W'(w)][init_cnt] <= 1'b0;
                age_mem[WAY_W'(w)][init_cnt]   <= AGE_W'(w);
            end
        end else if (accept) begin
            case (op)
                OP_WRITE: begin
                    if (hit) begin
                        data_mem[hit_way][idx]  <= wr_line;
                        dirty_mem[hit_way][idx] <= 1'b1;
                    end
                end
                OP_REFILL: begin
                    data_mem[vic_way][idx]  <= bus.req_line;
                    tag_mem[vic_way][idx]   <= tag;
                    valid_mem[vic_way][idx] <= 1'b1;
                    dirty_mem[vic_way][idx] <= 1'b0;
                end
                OP_INVAL: begin
                    if (hit) begin
                        valid_mem[hit_way][idx] <= 1'b0;
                        dirty_mem[hit_way][idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (touch_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way) begin
                        age_mem[WAY_W'(w)][idx] <= '0;
                    end else if (age_mem[WAY_W'(w)][idx] < touch_age) begin
                        age_mem[WAY_W'(w)][idx] <= age_mem[WAY_W'(w)][idx] + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response next-state
    // ------------------------------------------------------------------
    logic              rsp_hit_d;
    logic [WAY_W-1:0]  rsp_way_d;
    logic [31:0]       rsp_rdata_d;
    logic              vic_valid_d;
    logic              vic_dirty_d;
    logic [ADDR_W-1:0] vic_addr_d;
    logic [LINE_W-1:0] vic_line_d;

    always_comb begin
        rsp_hit_d   = 1'b0;
        rsp_way_d   = vic_way;
        rsp_rdata_d = '0;
        vic_valid_d = 1'b0;
        vic_dirty_d = 1'b0;
        vic_addr_d  = '0;
        vic_line_d  = '0;
        case (op)
            OP_READ, OP_WRITE: begin
                if (hit) begin
                    rsp_hit_d = 1'b1;
                    rsp_way_d = hit_way;
                    if (op == OP_READ) rsp_rdata_d = hit_line[word_base +: 32];
                end else if (vic_valid) begin
                    vic_valid_d = 1'b1;
                    vic_dirty_d = vic_dirty;
                    vic_addr_d  = {vic_tag, idx, {OFFSET_BITS{1'b0}}};
                    vic_line_d  = vic_line;
                end
            end
            OP_REFILL: begin
                if (vic_valid) begin
                    vic_valid_d = 1'b1;
                    vic_dirty_d = vic_dirty;
                    vic_addr_d  = {vic_tag, idx, {OFFSET_BITS{1'b0}}};
                    vic_line_d  = vic_line;
                end
            end
            OP_INVAL: begin
                if (hit) begin
                    rsp_hit_d   = 1'b1;
                    rsp_way_d   = hit_way;
                    vic_valid_d = 1'b1;
                    vic_dirty_d = hit_dirty;
                    vic_addr_d  = {tag, idx, {OFFSET_BITS{1'b0}}};
                    vic_line_d  = hit_line;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp_valid   <= 1'b0;
            bus.resp_hit     <= 1'b0;
            bus.resp_way     <= '0;
            bus.resp_rdata   <= '0;
            bus.victim_valid <= 1'b0;
            bus.victim_dirty <= 1'b0;
            bus.victim_addr  <= '0;
            bus.victim_line  <= '0;
        end else begin
            bus.resp_valid <= accept;
            if (accept) begin
                bus.resp_hit     <= rsp_hit_d;
                bus.resp_way     <= rsp_way_d;
                bus.resp_rdata   <= rsp_rdata_d;
                bus.victim_valid <= vic_valid_d;
                bus.victim_dirty <= vic_dirty_d;
                bus.victim_addr  <= vic_addr_d;
                bus.victim_line  <= vic_line_d;
            end
        end
    end
endmodule

// File: tb/tb_dcache_assoc_array.sv
// ---------------------------------------------------------------------------
// tb_dcache_assoc_array
// Directed vector table for the documented access sequence, hand-written
// reset / mid-operation reset sequences, and a randomized phase checked
// against a recency-timestamp model of the cache array.
// ---------------------------------------------------------------------------
module tb_dcache_assoc_array;
    localparam int WAYS        = 2;
    localparam int INDEX_BITS  = 6;
    localparam int OFFSET_BITS = 5;
    localparam int ADDR_W      = 32;
    localparam int SETS        = 2 ** INDEX_BITS;
    localparam int WORDS       = 2 ** (OFFSET_BITS - 2);
    localparam int TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_W       = 1;

    typedef logic [WORDS-1:0][31:0] line_t;

    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
        logic [31:0]      rdata;
        logic             vv;
        logic             vd;
        logic [31:0]      vaddr;
        line_t            vline;
    } resp_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       be;
        logic [31:0]      lbase;
        logic             hit;
        logic [WAY_W-1:0] way;
        logic [31:0]      rdata;
        logic             vv;
        logic             vd;
        logic [31:0]      vaddr;
        logic [31:0]      vw2;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
    int   tests;
    int   failed;

    always #5 clk = ~clk;

    dcache_assoc_array_if #(.WAYS(WAYS), .OFFSET_BITS(OFFSET_BITS), .ADDR_W(ADDR_W)) bus ();

    dcache_assoc_array #(
        .WAYS(WAYS), .INDEX_BITS(INDEX_BITS), .OFFSET_BITS(OFFSET_BITS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .init_done(init_done)
    );

    // ---------------- reference model ----------------
    logic             m_valid [WAYS][SETS];
    logic             m_dirty [WAYS][SETS];
    logic [TAG_W-1:0] m_tag   [WAYS][SETS];
    line_t            m_data  [WAYS][SETS];
    int               m_stamp [WAYS][SETS];
    int               now_t;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_stamp[w][s] = -w;   // way 0 most recent, highest way least
            end
        now_t = 0;
    endtask

    function automatic logic model_has(input logic [31:0] addr);
        logic r = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][addr[10:5]] && m_tag[w][addr[10:5]] == addr[31:11]) r = 1'b1;
        return r;
    endfunction

    task automatic model_step(input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input line_t line, output resp_t e);
        logic [INDEX_BITS-1:0] s;
        logic [TAG_W-1:0]      t;
        logic [2:0]            wd;
        int                    hw, vw;
        logic [31:0]           mask;
        s  = addr[10:5];
        t  = addr[31:11];
        wd = addr[4:2];
        hw = -1;
        vw = -1;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_valid[w][s] && m_tag[w][s] == t) hw = w;
        for (int w = 0; w < WAYS; w++)
            if (vw < 0 && !m_valid[w][s]) vw = w;
        if (vw < 0) begin
            vw = 0;
            for (int w = 1; w < WAYS; w++)
                if (m_stamp[w][s] < m_stamp[vw][s]) vw = w;
        end
        e = '0;
        e.way = WAY_W'(vw);
        if (hw >= 0 && op != 2'b10) begin
            e.hit = 1'b1;
            e.way = WAY_W'(hw);
        end
        case (op)
            2'b00, 2'b01: begin
                if (hw >= 0) begin
                    if (op == 2'b00) begin
                        e.rdata = m_data[hw][s][wd];
                    end else begin
                        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                        m_data[hw][s][wd] = (m_data[hw][s][wd] & ~mask) | (wdata & mask);
                        m_dirty[hw][s] = 1'b1;
                    end
                    now_t++;
                    m_stamp[hw][s] = now_t;
                end else if (m_valid[vw][s]) begin
                    e.vv = 1'b1; e.vd = m_dirty[vw][s];
                    e.vaddr = {m_tag[vw][s], s, 5'b0}; e.vline = m_data[vw][s];
                end
            end
            2'b10: begin
                if (m_valid[vw][s]) begin
                    e.vv = 1'b1; e.vd = m_dirty[vw][s];
                    e.vaddr = {m_tag[vw][s], s, 5'b0}; e.vline = m_data[vw][s];
                end
                m_data[vw][s] = line; m_tag[vw][s] = t;
                m_valid[vw][s] = 1'b1; m_dirty[vw][s] = 1'b0;
                now_t++;
                m_stamp[vw][s] = now_t;
            end
            default: begin
                if (hw >= 0) begin
                    e.vv = 1'b1; e.vd = m_dirty[hw][s];
                    e.vaddr = {t, s, 5'b0}; e.vline = m_data[hw][s];
                    m_valid[hw][s] = 1'b0; m_dirty[hw][s] = 1'b0;
                end
            end
        endcase
    endtask

    // ---------------- helpers ----------------
    function automatic line_t mk_line(input logic [31:0] base);
        line_t l;
        for (int k = 0; k < WORDS; k++) l[k] = base + 32'(k);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input line_t line);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.req_line  = line;
    endtask

    task automatic check(input string name, input logic ev, input resp_t e_in, input logic full);
        resp_t g, e;
        logic [31:0] gw, ew;
        e = e_in;
        g.hit = bus.resp_hit; g.way = bus.resp_way; g.rdata = bus.resp_rdata;
        g.vv = bus.victim_valid; g.vd = bus.victim_dirty;
        g.vaddr = bus.victim_addr; g.vline = bus.victim_line;
        if (!full) begin
            gw = g.vline[2]; ew = e.vline[2];
            g.vline = '0; e.vline = '0;
            g.vline[2] = gw; e.vline[2] = ew;
        end
        tests++;
        if (bus.resp_valid !== ev || (ev && g !== e)) begin
            failed++;
            $display("FAIL %s: got v=%0d hit=%0d way=%0d rdata=%h vv=%0d vd=%0d va=%h vline=%h | want v=%0d hit=%0d way=%0d rdata=%h vv=%0d vd=%0d va=%h vline=%h",
                     name, bus.resp_valid, g.hit, g.way, g.rdata, g.vv, g.vd, g.vaddr, g.vline,
                     ev, e.hit, e.way, e.rdata, e.vv, e.vd, e.vaddr, e.vline);
        end
    endtask

    task automatic check_reset(input string name);
        tests++;
        if (bus.req_ready !== 1'b0 || init_done !== 1'b0 || bus.resp_valid !== 1'b0 ||
            bus.resp_hit !== 1'b0 || bus.resp_way !== '0 || bus.resp_rdata !== '0 ||
            bus.victim_valid !== 1'b0 || bus.victim_dirty !== 1'b0 ||
            bus.victim_addr !== '0 || bus.victim_line !== '0) begin
            failed++;
            $display("FAIL %s: got ready=%0d init_done=%0d v=%0d hit=%0d way=%0d rdata=%h vv=%0d vd=%0d va=%h, want all zero",
                     name, bus.req_ready, init_done, bus.resp_valid, bus.resp_hit, bus.resp_way,
                     bus.resp_rdata, bus.victim_valid, bus.victim_dirty, bus.victim_addr);
        end
    endtask

    // Assumes rst was released just after a rising edge.
    task automatic init_wait(input string name);
        int   cyc = 0;
        logic bad = 1'b0;
        while (bus.req_ready !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
            if (init_done !== bus.req_ready) bad = 1'b1;
        end
        tests++;
        if (cyc != SETS || bad || init_done !== 1'b1) begin
            failed++;
            $display("FAIL %s: ready after %0d cycles (init_done=%0d, mismatch=%0d), want %0d cycles with init_done=1",
                     name, cyc, init_done, bad, SETS);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    vec_t  vecs [13];
    resp_t e;
    line_t rl;

    initial begin
        tests  = 0;
        failed = 0;
        //         op     addr          wdata         be    lbase         hit   way   rdata         vv    vd    vaddr         vw2
        vecs[0]  = '{2'd0, 32'h0000_1048, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{2'd2, 32'h0000_1040, 32'h0,        4'h0, 32'h1111_0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{2'd0, 32'h0000_1048, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h1111_0002, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{2'd1, 32'h0000_1048, 32'hAABB_CCDD, 4'h3, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{2'd0, 32'h0000_1048, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h1111_CCDD, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[5]  = '{2'd2, 32'h0000_2040, 32'h0,        4'h0, 32'h2222_0000, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[6]  = '{2'd0, 32'h0000_1040, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h1111_0000, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{2'd2, 32'h0000_3040, 32'h0,        4'h0, 32'h3333_0000, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0000_2040, 32'h2222_0002};
        vecs[8]  = '{2'd0, 32'h0000_3040, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1, 32'h3333_0000, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[9]  = '{2'd2, 32'h0000_4040, 32'h0,        4'h0, 32'h4444_0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_1040, 32'h1111_CCDD};
        vecs[10] = '{2'd1, 32'h0000_4044, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[11] = '{2'd3, 32'h0000_4040, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_4040, 32'h4444_0002};
        vecs[12] = '{2'd0, 32'h0000_4040, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};

        rst = 1'b1;
        drive(1'b0, 2'd0, '0, '0, '0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_values");
        rst = 1'b0;
        init_wait("init_sweep");

        // Directed sequence, back-to-back with no idle cycles
        for (int i = 0; i < 13; i++) begin
            resp_t te;
            drive(1'b1, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].be, mk_line(vecs[i].lbase));
            model_step(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].be, mk_line(vecs[i].lbase), e);
            tick();
            te = '0;
            te.hit = vecs[i].hit; te.way = vecs[i].way; te.rdata = vecs[i].rdata;
            te.vv = vecs[i].vv; te.vd = vecs[i].vd; te.vaddr = vecs[i].vaddr;
            te.vline[2] = vecs[i].vw2;
            check($sformatf("vec%0d", i), 1'b1, te, 1'b0);
        end

        // Reset asserted while a read is presented: response dropped, init reruns
        drive(1'b1, 2'd0, 32'h0000_3040, '0, '0, '0);
        #2 rst = 1'b1;
        #1 check_reset("rst_async");
        tick();
        check_reset("rst_drop");
        rst = 1'b0;
        drive(1'b0, 2'd0, '0, '0, '0, '0);
        init_wait("reinit_sweep");
        model_reset();
        drive(1'b1, 2'd0, 32'h0000_3040, '0, '0, '0);
        model_step(2'd0, 32'h0000_3040, '0, '0, '0, e);
        tick();
        check("rst_read_miss", 1'b1, e, 1'b1);

        // Randomized traffic over a few sets and tags to force hits and evictions
        for (int i = 0; i < 600; i++) begin
            logic        v;
            logic [1:0]  op;
            logic [31:0] addr, wdata;
            logic [3:0]  be;
            v     = ($urandom_range(0, 7) != 0);
            op    = 2'($urandom_range(0, 3));
            addr  = {21'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            for (int k = 0; k < WORDS; k++) rl[k] = $urandom;
            if (op == 2'b10 && model_has(addr)) op = 2'b00;
            drive(v, op, addr, wdata, be, rl);
            e = '0;
            if (v) model_step(op, addr, wdata, be, rl, e);
            tick();
            check($sformatf("rand%0d", i), v, e, 1'b1);
        end

        drive(1'b0, 2'd0, '0, '0, '0, '0);
        tick();
        check("idle", 1'b0, e, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
